// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared constants for the RV32M multiply/divide sequencer:
//                default operand width, funct3 op codes, FSM state encoding
//                and a helper to classify divide-family ops.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    // M-extension funct3 op codes
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // All divide/remainder ops have funct3[2] set
    function automatic logic is_div(input logic [2:0] funct3);
        return funct3[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_divstep.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_divstep
//  Description : One combinational restoring-divide iteration. Shifts the
//                next dividend bit into the partial remainder and subtracts
//                the divisor when it fits.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_divstep #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_rem,
    input  logic         i_dividend_bit,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_rem,
    output logic         o_quo_bit
);

    logic [W:0] w_shifted;

    // Trial subtract; the partial remainder is always below the divisor, so
    // the difference fits in W bits whenever the subtraction succeeds.
    always_comb begin
        w_shifted = {i_rem, i_dividend_bit};
        o_quo_bit = (w_shifted >= {1'b0, i_divisor});
        o_rem     = o_quo_bit ? (w_shifted[W-1:0] - i_divisor) : w_shifted[W-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_seq_unit
//  Description : Iterative RV32M multiply/divide sequencer. Shift-add
//                multiply and restoring divide on operand magnitudes, with
//                sign fix-up on entry to DONE. Result is held until taken.
//                Optional macro MDU_FAST_MUL_EN: single-cycle multiplier for
//                MUL* ops (divide path unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            iClk,
    input  logic            iRstN,
    input  logic            iReqValid,
    output logic            oReqReady,
    input  logic [2:0]      iFunct3,
    input  logic [XLEN-1:0] iOpA,
    input  logic [XLEN-1:0] iOpB,
    input  logic            iFlush,
    output logic            oRespValid,
    input  logic            iRespReady,
    output logic [XLEN-1:0] oResult
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q,  state_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              sa_q, sa_d, sb_q, sb_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   b_q, b_d;          // multiplicand / divisor magnitude
    logic [2*XLEN-1:0] prod_q, prod_d;    // {accumulator, multiplier}
    logic [XLEN-1:0]   quo_q, quo_d;      // dividend shifting out, quotient in
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode at accept
    logic            w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div0, w_ovf, w_fast, w_short;

    assign w_a_signed = (iFunct3 == F3_MULH) || (iFunct3 == F3_MULHSU) ||
                        (iFunct3 == F3_DIV)  || (iFunct3 == F3_REM);
    assign w_b_signed = (iFunct3 == F3_MULH) || (iFunct3 == F3_DIV) || (iFunct3 == F3_REM);
    assign w_a_neg    = w_a_signed & iOpA[XLEN-1];
    assign w_b_neg    = w_b_signed & iOpB[XLEN-1];
    assign w_a_mag    = w_a_neg ? -iOpA : iOpA;
    assign w_b_mag    = w_b_neg ? -iOpB : iOpB;
    assign w_div0     = is_div(iFunct3) && (iOpB == '0);
    assign w_ovf      = ((iFunct3 == F3_DIV) || (iFunct3 == F3_REM)) &&
                        (iOpA == INT_MIN) && (iOpB == '1);
`ifdef MDU_FAST_MUL_EN
    assign w_fast     = !is_div(iFunct3);
`else
    assign w_fast     = 1'b0;
`endif
    assign w_short    = w_div0 | w_ovf | w_fast;

    // Iteration datapath
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_prod_step;
    logic [XLEN-1:0]   w_rem_nxt;
    logic              w_qbit;

    assign w_mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, b_q} : '0);
    assign w_prod_step = {w_mul_sum, prod_q[XLEN-1:1]};

    mdu_divstep #(.W(XLEN)) u_divstep (
        .i_rem          (rem_q),
        .i_dividend_bit (quo_q[XLEN-1]),
        .i_divisor      (b_q),
        .o_rem          (w_rem_nxt),
        .o_quo_bit      (w_qbit)
    );

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_a_mag} * {{XLEN{1'b0}}, w_b_mag};
`endif

    // Apply operand signs to the magnitude results and select the output word
    function automatic logic [XLEN-1:0] fixup(input logic [2:0]        f3,
                                               input logic [2*XLEN-1:0] prod,
                                               input logic [XLEN-1:0]   quo,
                                               input logic [XLEN-1:0]   rem,
                                               input logic              sa,
                                               input logic              sb);
        logic [2*XLEN-1:0] p_s;
        logic [XLEN-1:0]   q_s, r_s;
        p_s = (sa ^ sb) ? -prod : prod;
        q_s = (sa ^ sb) ? -quo  : quo;
        r_s = sa ? -rem : rem;
        case (f3)
            F3_MUL:                        fixup = p_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fixup = p_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fixup = q_s;
            F3_REM, F3_REMU:               fixup = r_s;
            default:                       fixup = '0;
        endcase
    endfunction

    // State and datapath registers, cleared by asynchronous reset
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q  <= ST_IDLE;
            funct3_q <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    // Next-state logic; flush overrides every other input
    always_comb begin
        state_d = state_q;
        if (iFlush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (iReqValid) state_d = w_short ? ST_DONE : ST_CALC;
                ST_CALC: if (cnt_q == CNT_LAST) state_d = ST_DONE;
                ST_DONE: if (iRespReady) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath: operand capture at accept, one iteration per CALC cycle
    always_comb begin
        funct3_d = funct3_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;
        b_d      = b_q;
        prod_d   = prod_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        result_d = result_q;
        if (!iFlush) begin
            case (state_q)
                ST_IDLE: begin
                    if (iReqValid) begin
                        funct3_d = iFunct3;
                        sa_d     = w_a_neg;
                        sb_d     = w_b_neg;
                        cnt_d    = '0;
                        b_d      = w_b_mag;
                        rem_d    = '0;
                        if (is_div(iFunct3)) begin
                            quo_d  = w_a_mag;
                            prod_d = '0;
                        end else begin
                            quo_d  = '0;
                            prod_d = {{XLEN{1'b0}}, w_a_mag};
                        end
                        if (w_div0) begin
                            result_d = iFunct3[1] ? iOpA : '1;
                        end else if (w_ovf) begin
                            result_d = iFunct3[1] ? '0 : INT_MIN;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (w_fast) begin
                            result_d = fixup(iFunct3, w_fast_prod, '0, '0, w_a_neg, w_b_neg);
                        end
`endif
                    end
                end
                ST_CALC: begin
                    cnt_d = cnt_q + CW'(1);
                    if (is_div(funct3_q)) begin
                        quo_d = {quo_q[XLEN-2:0], w_qbit};
                        rem_d = w_rem_nxt;
                    end else begin
                        prod_d = w_prod_step;
                    end
                    if (cnt_q == CNT_LAST) begin
                        result_d = fixup(funct3_q, prod_d, quo_d, rem_d, sa_q, sb_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        oReqReady  = (state_q == ST_IDLE);
        oRespValid = (state_q == ST_DONE);
        oResult    = result_q;
    end

endmodule
`default_nettype wire

// File: doc/mdu_seq_unit.md
Name: mdu_seq_unit

Overview:
- Iterative RV32M multiply/divide sequencer beside the main ALU in EX.
- Accepts one M-extension op (funct7=0000001) via valid/ready handshake.
- Runs a multi-cycle shift-add multiply or restoring divide FSM, then holds the result until the pipeline takes it.
- The hazard logic stalls EX while oReqReady is low or a response is pending.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- iClk  in  1  clock, all state updates on rising edge
- iRstN  in  1  asynchronous active-low reset
- iReqValid  in  1  request present
- oReqReady  out  1  unit can accept a request (high only in IDLE)
- iFunct3  in  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- iOpA  in  XLEN  rs1 value
- iOpB  in  XLEN  rs2 value
- iFlush  in  1  abort the in-flight op (branch mispredict or trap)
- oRespValid  out  1  result available
- iRespReady  in  1  consumer takes result
- oResult  out  XLEN  result; held stable while oRespValid=1

Behaviour:
- Reset (iRstN=0, async): state=IDLE, oReqReady=1, oRespValid=0, oResult=0, all internal registers cleared. Reset mid-operation discards the op; no response is produced.
- States: IDLE, CALC, DONE.
- IDLE:
  - oReqReady=1.
  - On iReqValid (accept cycle): latch funct3; latch operand magnitudes and sign flags.
  - Sign rules: A is signed for MULH, MULHSU, DIV and REM. B is signed for MULH, DIV and REM.
  - Next state is CALC with counter=0, unless a special case applies (below).
- Special cases, decided at accept; go directly to DONE, so oRespValid rises 1 cycle after accept:
  - Divide by zero (DIV/DIVU/REM/REMU, B=0): quotient=all ones; remainder=iOpA.
  - Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- CALC:
  - One iteration per cycle.
  - Counter runs 0..XLEN-1; at counter=XLEN-1 the FSM goes to DONE.
  - Multiply: 2*XLEN-bit product register, shift-add on magnitudes.
  - Divide: restoring divide on magnitudes; produces quotient and remainder registers.
- Latency: oRespValid asserts XLEN+1 cycles after the accept edge (33 for XLEN=32).
- Sign fix-up: applied combinationally on entry to DONE and registered into oResult.
  - Product is negated if the operand signs differ.
  - Quotient sign = sA^sB; remainder sign = sA.
- Result select:
  - MUL returns low XLEN bits.
  - MULH, MULHSU and MULHU return high XLEN bits.
- DONE:
  - oRespValid=1 and oResult stable until iRespReady=1.
  - On handshake the FSM returns to IDLE; oRespValid=0 next cycle.
  - No new request is accepted in the handshake cycle (no bypass); oReqReady=0 in CALC and DONE.
- iFlush (any state): next state IDLE, oRespValid=0 next cycle.
  - iFlush wins over iReqValid and iRespReady in the same cycle.
  - A request presented together with iFlush is not accepted.
- iReqValid while not in IDLE: ignored; the requester must hold it until oReqReady=1.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - MUL* ops compute with a single-cycle 2*XLEN multiplier at accept and go directly to DONE; oRespValid rises 1 cycle after accept.
  - DIV* ops are unchanged.
- Undefined: all multiplies use the iterative XLEN-cycle path; no hardware multiplier is inferred.

Decomposition:
- Package mdu_pkg:
  - XLEN default.
  - funct3 op localparams: MUL..REMU.
  - State encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Helper function is_div(funct3) = funct3[2].
- Sub-module mdu_divstep: purely combinational single restoring-divide iteration.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
- Multiply path and FSM stay in mdu_seq_unit.

Test Plan:
- MUL A=7, B=0xFFFFFFFD -> oResult=0xFFFFFFEB; oRespValid exactly 33 cycles after accept (1 with MDU_FAST_MUL_EN).
- MULH A=B=0x80000000 -> 0x40000000. MULHU A=B=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU A=100, B=7 -> 14. REMU A=100, B=7 -> 2.
- DIVU A=10, B=0 -> 0xFFFFFFFF; REMU A=10, B=0 -> 10; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM same -> 0. Each response 1 cycle after accept.
- Backpressure: iRespReady low 5 cycles in DONE -> oResult/oRespValid stable; a new iReqValid meanwhile is not accepted (oReqReady=0).
- iFlush at CALC cycle 10, and async iRstN pulse at cycle 20 of a new DIV -> IDLE, no response, oReqReady=1; next MUL 3*4 -> 12.
